// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute through a shared ALU and unified memory.
// Optional sticky illegal-opcode trap state enabled by defining MULTICYCLE_ILLEGAL_TRAP_EN.
module multicycle_controller #(
  parameter int ALU_CTRL_W    = 3,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [6:0]            i_opcode,
  input  logic [2:0]            i_funct3,
  input  logic                  i_funct7b5,
  input  logic                  i_n,
  input  logic                  i_z,
  input  logic                  i_c,
  input  logic                  i_v,
  input  logic                  i_mem_ready,
  output logic                  o_mem_req,
  output logic                  o_mem_wren,
  output logic                  o_adr_sel,
  output logic                  o_ir_wren,
  output logic                  o_pc_wren,
  output logic                  o_regfile_wren,
  output logic [1:0]            o_alu_asel,
  output logic [1:0]            o_alu_bsel,
  output logic [1:0]            o_result_sel,
  output logic [2:0]            o_ximm_sel,
  output logic [ALU_CTRL_W-1:0] o_alu_control
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  , output logic                o_illegal_instr
`endif
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_JAL, S_JALR, S_JALRWB, S_BRANCH, S_LUI, S_TRAP
  } state_t;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(9);

  localparam logic [2:0] XIMM_I = 3'b000;
  localparam logic [2:0] XIMM_S = 3'b001;
  localparam logic [2:0] XIMM_B = 3'b010;
  localparam logic [2:0] XIMM_U = 3'b100;

  state_t r_state;
  state_t w_next;

  logic                  w_mem_done;
  logic                  w_take;
  logic [ALU_CTRL_W-1:0] w_func_op;
  logic                  w_mem_req, w_mem_wren, w_ir_wren, w_pc_wren, w_rf_wren;

  assign w_mem_done = (MEM_HANDSHAKE == 0) ? 1'b1 : i_mem_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_FETCH;
    else         r_state <= w_next;
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge i_clk) begin
    if (i_reset)               r_illegal <= 1'b0;
    else if (w_next == S_TRAP) r_illegal <= 1'b1;
  end
  assign o_illegal_instr = r_illegal;
`endif

  // funct7b5 only matters for R-type sub and for the arithmetic right shift
  always_comb begin
    w_func_op = ALU_ADD;
    case (i_funct3)
      3'b000: w_func_op = (r_state == S_EXECR && i_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: w_func_op = ALU_SLL;
      3'b010: w_func_op = ALU_SLT;
      3'b011: w_func_op = ALU_SLTU;
      3'b100: w_func_op = ALU_XOR;
      3'b101: w_func_op = (ALU_CTRL_W == 4) ? (i_funct7b5 ? ALU_SRA : ALU_SRL) : ALU_ADD;
      3'b110: w_func_op = ALU_OR;
      3'b111: w_func_op = ALU_AND;
      default: w_func_op = ALU_ADD;
    endcase
  end

  always_comb begin
    w_take = 1'b0;
    case (i_funct3)
      3'b000: w_take = i_z;
      3'b001: w_take = ~i_z;
      3'b100: w_take = i_n ^ i_v;
      3'b101: w_take = ~(i_n ^ i_v);
      3'b110: w_take = ~i_c;
      3'b111: w_take = i_c;
      default: w_take = 1'b0;
    endcase
  end

  always_comb begin
    w_next         = r_state;
    w_mem_req      = 1'b0;
    w_mem_wren     = 1'b0;
    w_ir_wren      = 1'b0;
    w_pc_wren      = 1'b0;
    w_rf_wren      = 1'b0;
    o_adr_sel      = 1'b0;
    o_alu_asel     = 2'b00;
    o_alu_bsel     = 2'b00;
    o_result_sel   = 2'b00;
    o_ximm_sel     = XIMM_I;
    o_alu_control  = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        o_alu_bsel = 2'b10;
        if (w_mem_done) begin
          w_ir_wren    = 1'b1;
          w_pc_wren    = 1'b1;
          o_result_sel = 2'b10;
          w_next       = S_DECODE;
        end
      end
      S_DECODE: begin
        o_alu_asel = 2'b01;
        o_alu_bsel = 2'b01;
        o_ximm_sel = XIMM_B;
        case (i_opcode)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECR;
          7'b0010011:             w_next = S_EXECI;
          7'b1101111:             w_next = S_JAL;
          7'b1100111:             w_next = S_JALR;
          7'b1100011:             w_next = S_BRANCH;
          7'b0110111:             w_next = S_LUI;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:                w_next = S_TRAP;
`else
          default:                w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        o_alu_asel = 2'b10;
        o_alu_bsel = 2'b01;
        o_ximm_sel = i_opcode[5] ? XIMM_S : XIMM_I;
        w_next     = i_opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        o_adr_sel = 1'b1;
        if (w_mem_done) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_result_sel = 2'b01;
        w_rf_wren    = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req  = 1'b1;
        w_mem_wren = 1'b1;
        o_adr_sel  = 1'b1;
        if (w_mem_done) w_next = S_FETCH;
      end
      S_EXECR: begin
        o_alu_asel    = 2'b10;
        o_alu_control = w_func_op;
        w_next        = S_ALUWB;
      end
      S_EXECI: begin
        o_alu_asel    = 2'b10;
        o_alu_bsel    = 2'b01;
        o_alu_control = w_func_op;
        w_next        = S_ALUWB;
      end
      S_ALUWB: begin
        w_rf_wren = 1'b1;
        w_next    = S_FETCH;
      end
      // PC takes the target latched during DECODE while the ALU forms oldPC+4
      S_JAL: begin
        o_alu_asel = 2'b01;
        o_alu_bsel = 2'b10;
        w_pc_wren  = 1'b1;
        w_next     = S_ALUWB;
      end
      S_JALR: begin
        o_alu_asel   = 2'b10;
        o_alu_bsel   = 2'b01;
        o_result_sel = 2'b10;
        w_pc_wren    = 1'b1;
        w_next       = S_JALRWB;
      end
      S_JALRWB: begin
        o_alu_asel   = 2'b01;
        o_alu_bsel   = 2'b10;
        o_result_sel = 2'b10;
        w_rf_wren    = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_asel    = 2'b10;
        o_alu_control = ALU_SUB;
        w_pc_wren     = w_take;
        w_next        = S_FETCH;
      end
      S_LUI: begin
        o_result_sel = 2'b11;
        o_ximm_sel   = XIMM_U;
        w_rf_wren    = 1'b1;
        w_next       = S_FETCH;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: w_next = S_TRAP;
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // Reset must silence every write strobe in the same cycle, even mid-store
  assign o_mem_req      = w_mem_req  & ~i_reset;
  assign o_mem_wren     = w_mem_wren & ~i_reset;
  assign o_ir_wren      = w_ir_wren  & ~i_reset;
  assign o_pc_wren      = w_pc_wren  & ~i_reset;
  assign o_regfile_wren = w_rf_wren  & ~i_reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected step sequence built from the ISA rules,
// random opcodes/stalls/operands, plus literal pins for the directed scenarios.
module tb_multicycle_controller;
  localparam int W = 3;

  logic clk = 1'b0;
  logic reset, funct7b5, n_f, z_f, c_f, v_f, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic mem_req, mem_wren, adr_sel, ir_wren, pc_wren, regfile_wren;
  logic [1:0] alu_asel, alu_bsel, result_sel;
  logic [2:0] ximm_sel;
  logic [W-1:0] alu_control;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic illegal_instr;
`endif

  always #5 clk = ~clk;

  multicycle_controller #(.ALU_CTRL_W(W), .MEM_HANDSHAKE(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_funct3(funct3), .i_funct7b5(funct7b5),
    .i_n(n_f), .i_z(z_f), .i_c(c_f), .i_v(v_f), .i_mem_ready(mem_ready),
    .o_mem_req(mem_req), .o_mem_wren(mem_wren), .o_adr_sel(adr_sel), .o_ir_wren(ir_wren),
    .o_pc_wren(pc_wren), .o_regfile_wren(regfile_wren), .o_alu_asel(alu_asel),
    .o_alu_bsel(alu_bsel), .o_result_sel(result_sel), .o_ximm_sel(ximm_sel),
    .o_alu_control(alu_control)
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , .o_illegal_instr(illegal_instr)
`endif
  );

  typedef struct packed {
    logic req, wren, adr, ir, pc, rf;
    logic [1:0] asel, bsel, rsel;
    logic [2:0] xsel;
    logic [2:0] aluc;
  } outs_t;

  outs_t got;
  assign got = {mem_req, mem_wren, adr_sel, ir_wren, pc_wren, regfile_wren,
                alu_asel, alu_bsel, result_sel, ximm_sel, alu_control};

  localparam int ST_FWAIT = 0, ST_FGO = 1, ST_DEC = 2, ST_MADR = 3, ST_MR = 4, ST_MWB = 5,
                 ST_MW = 6, ST_EXR = 7, ST_EXI = 8, ST_AWB = 9, ST_JAL = 10, ST_JALR = 11,
                 ST_JWB = 12, ST_BR = 13, ST_LUI = 14, ST_TRAP = 15;
  string st_name[16] = '{"fetch_wait", "fetch_go", "decode", "memadr", "memread", "memwb",
                         "memwrite", "execr", "execi", "aluwb", "jal", "jalr", "jalrwb",
                         "branch", "lui", "trap"};

  int n_checks = 0, n_fail = 0, n_cyc = 0;
  int g_fetch_forced = -1, g_mem_forced = -1;
  logic g_rand_ops = 1'b1, g_take = 1'b0;
  logic [31:0] g_a, g_b;
  outs_t seen[16];

  // RV32I funct3 meaning -> ALU code (add0 sub1 and2 or3 xor4 slt5 sltu6 sll7; shifts right unsupported at W=3)
  function automatic logic [2:0] alu_model(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (is_r && f7) ? 3'd1 : 3'd0;
      3'd1: return 3'd7;
      3'd2: return 3'd5;
      3'd3: return 3'd6;
      3'd4: return 3'd4;
      3'd6: return 3'd3;
      3'd7: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic outs_t expect_step(input int st, input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7, input logic take);
    outs_t e;
    e = '0;
    case (st)
      ST_FWAIT: begin e.req = 1; e.bsel = 2; end
      ST_FGO:   begin e.req = 1; e.bsel = 2; e.ir = 1; e.pc = 1; e.rsel = 2; end
      ST_DEC:   begin e.asel = 1; e.bsel = 1; e.xsel = 3'b010; end
      ST_MADR:  begin e.asel = 2; e.bsel = 1; e.xsel = op[5] ? 3'b001 : 3'b000; end
      ST_MR:    begin e.req = 1; e.adr = 1; end
      ST_MWB:   begin e.rsel = 1; e.rf = 1; end
      ST_MW:    begin e.req = 1; e.wren = 1; e.adr = 1; end
      ST_EXR:   begin e.asel = 2; e.aluc = alu_model(1'b1, f3, f7); end
      ST_EXI:   begin e.asel = 2; e.bsel = 1; e.aluc = alu_model(1'b0, f3, f7); end
      ST_AWB:   begin e.rf = 1; end
      ST_JAL:   begin e.asel = 1; e.bsel = 2; e.pc = 1; end
      ST_JALR:  begin e.asel = 2; e.bsel = 1; e.rsel = 2; e.pc = 1; end
      ST_JWB:   begin e.asel = 1; e.bsel = 2; e.rsel = 2; e.rf = 1; end
      ST_BR:    begin e.asel = 2; e.aluc = 3'd1; e.pc = take; end
      ST_LUI:   begin e.rsel = 3; e.xsel = 3'b100; e.rf = 1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic cyc(input int st, input logic rdy);
    outs_t e;
    mem_ready = rdy;
    if (st != ST_BR) {n_f, z_f, c_f, v_f} = 4'($urandom_range(0, 15));
    @(negedge clk);
    e = expect_step(st, opcode, funct3, funct7b5, g_take);
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL step_%s op=%b f3=%b actual=%h required=%h", st_name[st], opcode, funct3, got, e);
    end
    seen[st] = got;
    n_cyc++;
    @(posedge clk); #1;
  endtask

  task automatic mem_phase(input int st_wait, input int st_go, input int forced);
    logic r;
    for (int k = 0; k < 8; k++) begin
      if (forced >= 0) r = (k >= forced);
      else             r = (k >= 4) || ($urandom_range(0, 2) == 0);
      cyc(r ? st_go : st_wait, r);
      if (r) break;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    {n_f, z_f, c_f, v_f} = 4'($urandom_range(0, 15));
    @(negedge clk);
    chk("reset_enables", {27'd0, mem_req, mem_wren, ir_wren, pc_wren, regfile_wren}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    chk("reset_illegal_clear", {31'd0, illegal_instr}, 32'd0);
`endif
  endtask

  // Branch flags come from a real subtraction of two operands; the decision from plain comparisons.
  task automatic set_branch_ops();
    logic [31:0] d;
    if (g_rand_ops) begin
      g_a = $urandom;
      g_b = ($urandom_range(0, 3) == 0) ? g_a : (($urandom_range(0, 1) == 0) ? $urandom : g_a + 32'($urandom_range(0, 3)) - 32'd1);
    end
    d = g_a - g_b;
    n_f = d[31];
    z_f = (d == 32'd0);
    c_f = (g_a >= g_b);
    v_f = (g_a[31] != g_b[31]) && (d[31] != g_a[31]);
    case (funct3)
      3'b000: g_take = (g_a == g_b);
      3'b001: g_take = (g_a != g_b);
      3'b100: g_take = ($signed(g_a) < $signed(g_b));
      3'b101: g_take = ($signed(g_a) >= $signed(g_b));
      3'b110: g_take = (g_a < g_b);
      3'b111: g_take = (g_a >= g_b);
      default: g_take = 1'b0;
    endcase
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7b5 = f7;
    mem_phase(ST_FWAIT, ST_FGO, g_fetch_forced);
    cyc(ST_DEC, 1'($urandom_range(0, 1)));
    case (op)
      7'b0000011: begin cyc(ST_MADR, 1'b1); mem_phase(ST_MR, ST_MR, g_mem_forced); cyc(ST_MWB, 1'b1); end
      7'b0100011: begin cyc(ST_MADR, 1'b1); mem_phase(ST_MW, ST_MW, g_mem_forced); end
      7'b0110011: begin cyc(ST_EXR, 1'b1); cyc(ST_AWB, 1'b1); end
      7'b0010011: begin cyc(ST_EXI, 1'b1); cyc(ST_AWB, 1'b1); end
      7'b1101111: begin cyc(ST_JAL, 1'b1); cyc(ST_AWB, 1'b1); end
      7'b1100111: begin cyc(ST_JALR, 1'b1); cyc(ST_JWB, 1'b1); end
      7'b1100011: begin set_branch_ops(); cyc(ST_BR, 1'($urandom_range(0, 1))); end
      7'b0110111: cyc(ST_LUI, 1'b1);
      default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) begin
          cyc(ST_TRAP, 1'($urandom_range(0, 1)));
          chk("trap_illegal_flag", {31'd0, illegal_instr}, 32'd1);
        end
        apply_reset();
`endif
      end
    endcase
  endtask

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                      7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111};
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [6:0] legal_ops[8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111};
    logic [6:0] op;
    reset = 1'b1; opcode = 7'h13; funct3 = 3'd0; funct7b5 = 1'b0;
    {n_f, z_f, c_f, v_f} = 4'd0; mem_ready = 1'b0;
    apply_reset();
    apply_reset();

    // add x3,x1,x2 with memory ready on the second fetch cycle: 5 cycles total
    g_fetch_forced = 1;
    c0 = n_cyc;
    run_instr(7'b0110011, 3'b000, 1'b0);
    chk("add_cycles", 32'(n_cyc - c0), 32'd5);
    chk("add_alu", {29'd0, seen[ST_EXR].aluc}, 32'd0);
    chk("add_aluwb_rf", {31'd0, seen[ST_AWB].rf}, 32'd1);
    chk("add_fetch_wait_ir", {31'd0, seen[ST_FWAIT].ir}, 32'd0);
    run_instr(7'b0110011, 3'b000, 1'b1);
    chk("sub_alu", {29'd0, seen[ST_EXR].aluc}, 32'd1);
    run_instr(7'b0010011, 3'b101, 1'b1);
    chk("srai_w3_alu", {29'd0, seen[ST_EXI].aluc}, 32'd0);
    run_instr(7'b0010011, 3'b000, 1'b1);
    chk("addi_f7_ignored", {29'd0, seen[ST_EXI].aluc}, 32'd0);

    // lw with three stall cycles in MEMREAD
    g_mem_forced = 3;
    c0 = n_cyc;
    run_instr(7'b0000011, 3'b010, 1'b0);
    chk("lw_cycles", 32'(n_cyc - c0), 32'd9);
    chk("lw_mwb_rsel", {30'd0, seen[ST_MWB].rsel}, 32'd1);
    chk("lw_mwb_rf", {31'd0, seen[ST_MWB].rf}, 32'd1);

    // branches with operand-derived flags
    g_rand_ops = 1'b0;
    g_a = 32'd5; g_b = 32'd5;
    run_instr(7'b1100011, 3'b000, 1'b0);
    chk("beq_z_flag", {31'd0, z_f}, 32'd1);
    chk("beq_taken", {31'd0, seen[ST_BR].pc}, 32'd1);
    run_instr(7'b1100011, 3'b001, 1'b0);
    chk("bne_not_taken", {31'd0, seen[ST_BR].pc}, 32'd0);
    g_a = 32'd1; g_b = 32'd2;
    run_instr(7'b1100011, 3'b100, 1'b0);
    chk("blt_nv_flags", {30'd0, n_f, v_f}, 32'd2);
    chk("blt_taken", {31'd0, seen[ST_BR].pc}, 32'd1);
    run_instr(7'b1100011, 3'b111, 1'b0);
    chk("bgeu_c_flag", {31'd0, c_f}, 32'd0);
    chk("bgeu_not_taken", {31'd0, seen[ST_BR].pc}, 32'd0);
    run_instr(7'b1100011, 3'b110, 1'b0);
    chk("bltu_taken", {31'd0, seen[ST_BR].pc}, 32'd1);
    g_a = 32'h8000_0000; g_b = 32'd1;
    run_instr(7'b1100011, 3'b101, 1'b0);
    chk("bge_overflow_not_taken", {31'd0, seen[ST_BR].pc}, 32'd0);
    g_rand_ops = 1'b1;

    run_instr(7'b1101111, 3'b000, 1'b0);
    chk("jal_pc", {31'd0, seen[ST_JAL].pc}, 32'd1);
    chk("jal_aluwb_rf", {31'd0, seen[ST_AWB].rf}, 32'd1);
    run_instr(7'b1100111, 3'b000, 1'b0);
    chk("jalr_pc", {31'd0, seen[ST_JALR].pc}, 32'd1);
    chk("jalrwb_rf", {31'd0, seen[ST_JWB].rf}, 32'd1);

    // reset during a stalled store
    opcode = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    mem_phase(ST_FWAIT, ST_FGO, 0);
    cyc(ST_DEC, 1'b0);
    cyc(ST_MADR, 1'b0);
    cyc(ST_MW, 1'b0);
    cyc(ST_MW, 1'b0);
    chk("mw_stall_wren", {31'd0, seen[ST_MW].wren}, 32'd1);
    apply_reset();
    cyc(ST_FWAIT, 1'b0);
    chk("rst_mw_wren", {31'd0, seen[ST_FWAIT].wren}, 32'd0);
    chk("rst_mw_fetch_req", {31'd0, seen[ST_FWAIT].req}, 32'd1);

    // unrecognised opcode
    g_mem_forced = -1;
    run_instr(7'h7F, 3'b000, 1'b0);
    cyc(ST_FWAIT, 1'b0);
    chk("illegal_no_write", {29'd0, seen[ST_FWAIT].rf, seen[ST_FWAIT].pc, seen[ST_FWAIT].ir}, 32'd0);

    // random instruction stream with random stalls
    g_fetch_forced = -1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 7'($urandom_range(0, 127));
        for (int t = 0; t < 16 && is_legal(op); t++) op = 7'($urandom_range(0, 127));
        if (is_legal(op)) op = 7'h7F;
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
